ad9634_cfg_sequencer: RTL and testbench
=======================================

AD9634_CFG_SEQUENCER -- requirements
Module: ad9634_cfg_sequencer

Interface
REQ-001 Parameters: NUM_WRITES, default 8, number of config-table entries; GAP_CYCLES, default 16, idle clocks between transfers (CS high time); TIMEOUT_CYCLES, default 4096, max clocks waiting on any controller edge; CHIP_ID_EXP, default 8'h87, expected value of register 0x001.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a configuration run; honoured only in IDLE.
REQ-005 spi_data  output  24  word to SPI controller: [23] R/W (1=read), [22:21] W1:W0=00 (single byte), [20:8] address, [7:0] data.
REQ-006 spi_load  output  1  one-cycle strobe; spi_data is valid in the same cycle.
REQ-007 spi_busy  input  1  high while the controller is shifting a word.
REQ-008 spi_rd_data  input  8  last byte shifted in on MISO; valid on the cycle spi_busy falls.
REQ-009 busy  output  1  high from accepted start until DONE or ERR.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 error  output  1  sticky; set on timeout or chip-ID mismatch; cleared by next accepted start or reset.
REQ-012 err_code  output  2  00 none, 01 busy-rise timeout, 10 busy-fall timeout, 11 chip-ID mismatch.

Function
REQ-013 Sequence per run: (1) read 0x001 (chip ID), compare with CHIP_ID_EXP; (2) write the NUM_WRITES table entries in index order 0..NUM_WRITES-1; (3) write 0x0FF=0x01 (transfer/update).
REQ-014 States: IDLE, ISSUE, WAIT_RISE, WAIT_FALL, GAP, CHECK, DONE, ERR.
REQ-015 IDLE -> ISSUE on start; error, err_code, index cleared on that edge.
REQ-016 ISSUE: drive spi_data for the current step, assert spi_load exactly one cycle, -> WAIT_RISE.
REQ-017 WAIT_RISE: -> WAIT_FALL when spi_busy=1; timeout counter reaching TIMEOUT_CYCLES -> ERR, err_code=01.
REQ-018 WAIT_FALL: on spi_busy=0 -> CHECK after the chip-ID read, else GAP; timeout -> ERR, err_code=10.
REQ-019 CHECK: spi_rd_data captured on the busy-fall cycle; equal -> GAP, unequal -> ERR, err_code=11; no table write issued after a mismatch.
REQ-020 GAP: count GAP_CYCLES clocks, then ISSUE the next step, or DONE after the 0x0FF write.
REQ-021 DONE: done=1 one cycle, -> IDLE. ERR: error=1, -> IDLE next cycle; error/err_code hold.
REQ-022 spi_data holds the last issued word between loads; spi_load never asserted outside ISSUE.
REQ-023 Timeout counter resets on every state entry; width clog2(TIMEOUT_CYCLES+1); saturates, no wrap.
REQ-024 start while busy=1 is ignored; no queueing.
REQ-025 spi_busy already high at ISSUE (stale) is not treated as a rise; WAIT_RISE samples from the cycle after spi_load.
REQ-026 Index counter width clog2(NUM_WRITES+2); NUM_WRITES=1 is legal.
REQ-027 Latency start -> first spi_load: 1 clock.

Reset
REQ-028 Asynchronous on rst_n low: state=IDLE, spi_load=0, spi_data=0, busy=0, done=0, error=0, err_code=00, counters=0.
REQ-029 Reset mid-transfer aborts with no further spi_load; after release the block waits for a new start.

Structure
REQ-030 Shared package: state encoding, err_code values, AD9634 address constants (CHIP_ID=0x001, TRANSFER=0x0FF), word-field positions, function building a 24-bit word from (rw, addr, data).
REQ-031 One sub-module: ad9634_cfg_rom, combinational index -> {addr[12:0], data[7:0]}; table contents live only there.

Verification
REQ-032 Nominal: start, controller model busy 2 clocks after load for 48 clocks, returns 0x87 -> 10 loads (read 0x001, 8 table, 0x0FF=0x01), done pulse, error=0.
REQ-033 Chip-ID mismatch: model returns 0x00 -> error=1, err_code=11, exactly 1 spi_load, no done.
REQ-034 No response: busy held 0 -> error after TIMEOUT_CYCLES, err_code=01, busy drops.
REQ-035 Stuck busy: busy held 1 after third load -> err_code=10, no fourth load.
REQ-036 Reset asserted during table entry 4 -> all outputs at reset values same cycle; later start reruns from chip-ID read.
REQ-037 Start pulsed during run and back-to-back after done -> mid-run start ignored; second run yields identical load sequence with GAP_CYCLES spacing.

Source files
------------

// File: rtl/ad9634_cfg_pkg.sv
// Shared definitions for the AD9634 configuration sequencer: FSM states, error codes,
// register addresses and the 24-bit SPI instruction word layout.
package ad9634_cfg_pkg;

    localparam int unsigned WORD_W = 24;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;

    // Bit positions of the instruction word fields
    localparam int unsigned RW_POS   = 23;
    localparam int unsigned W_MSB    = 22;
    localparam int unsigned W_LSB    = 21;
    localparam int unsigned ADDR_MSB = 20;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [ADDR_W-1:0] ADDR_CHIP_ID  = 13'h001;
    localparam logic [ADDR_W-1:0] ADDR_TRANSFER = 13'h0FF;
    localparam logic [DATA_W-1:0] DATA_TRANSFER = 8'h01;
    localparam logic [1:0]        W_SINGLE      = 2'b00;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        GAP       = 3'd4,
        CHECK     = 3'd5,
        DONE      = 3'd6,
        ERR       = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_RISE_TMO = 2'b01,
        ERR_FALL_TMO = 2'b10,
        ERR_CHIP_ID  = 2'b11
    } err_code_e;

    typedef struct packed {
        logic              rw;
        logic [1:0]        w;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_word_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cfg_entry_t;

    function automatic spi_word_t build_word(input logic              rw,
                                             input logic [ADDR_W-1:0] addr,
                                             input logic [DATA_W-1:0] data);
        spi_word_t w;
        w.rw   = rw;
        w.w    = W_SINGLE;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/ad9634_cfg_rom.sv
// AD9634 register configuration table; combinational lookup of entry i_idx.
module ad9634_cfg_rom
    import ad9634_cfg_pkg::*;
#(
    parameter int unsigned NUM_WRITES = 8,
    parameter int unsigned IDX_W      = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    output cfg_entry_t       o_entry_c
);

    // Entries past the populated table rewrite the SPI port config with its default
    always_comb begin
        o_entry_c = '{addr: 13'h000, data: 8'h18};
        if (32'(i_idx) < NUM_WRITES) begin
            case (32'(i_idx))
                0:       o_entry_c = '{addr: 13'h008, data: 8'h00};
                1:       o_entry_c = '{addr: 13'h009, data: 8'h01};
                2:       o_entry_c = '{addr: 13'h00B, data: 8'h00};
                3:       o_entry_c = '{addr: 13'h00D, data: 8'h00};
                4:       o_entry_c = '{addr: 13'h010, data: 8'h00};
                5:       o_entry_c = '{addr: 13'h014, data: 8'h01};
                6:       o_entry_c = '{addr: 13'h016, data: 8'h00};
                7:       o_entry_c = '{addr: 13'h018, data: 8'h04};
                default: o_entry_c = '{addr: 13'h000, data: 8'h18};
            endcase
        end
    end

endmodule

// File: rtl/ad9634_cfg_sequencer.sv
// Power-up configuration sequencer for the AD9634: verifies the chip ID, writes the
// register table through an external SPI controller, then issues the transfer/update.
module ad9634_cfg_sequencer
    import ad9634_cfg_pkg::*;
#(
    parameter int unsigned       NUM_WRITES     = 8,
    parameter int unsigned       GAP_CYCLES     = 16,
    parameter int unsigned       TIMEOUT_CYCLES = 4096,
    parameter logic [DATA_W-1:0] CHIP_ID_EXP    = 8'h87
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [WORD_W-1:0] spi_data,
    output logic              spi_load,
    input  logic              spi_busy,
    input  logic [DATA_W-1:0] spi_rd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned IDX_W = $clog2(NUM_WRITES + 2);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_STEP  = IDX_W'(NUM_WRITES + 1);
    localparam logic [IDX_W-1:0] XFER_PREV  = IDX_W'(NUM_WRITES);
    localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    state_e            r_state,    w_state_nxt;
    logic [IDX_W-1:0]  r_idx,      w_idx_nxt;
    logic [TMO_W-1:0]  r_tmo,      w_tmo_nxt;
    logic [GAP_W-1:0]  r_gap,      w_gap_nxt;
    spi_word_t         r_word,     w_word_nxt;
    logic              r_load,     w_load_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_error,    w_error_nxt;
    err_code_e         r_err_code, w_err_code_nxt;
    logic [DATA_W-1:0] r_rd_byte,  w_rd_byte_nxt;
    cfg_entry_t        w_entry;

    // Step index: 0 = chip-ID read, 1..NUM_WRITES = table, NUM_WRITES+1 = transfer.
    // While in GAP after step r_idx, the ROM already presents table entry r_idx.
    ad9634_cfg_rom #(
        .NUM_WRITES (NUM_WRITES),
        .IDX_W      (IDX_W)
    ) u_rom (
        .i_idx     (r_idx),
        .o_entry_c (w_entry)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_tmo_nxt      = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + TMO_W'(1);
        w_gap_nxt      = r_gap;
        w_word_nxt     = r_word;
        w_load_nxt     = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_err_code_nxt = r_err_code;
        w_rd_byte_nxt  = r_rd_byte;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt    = ISSUE;
                    w_idx_nxt      = '0;
                    w_error_nxt    = 1'b0;
                    w_err_code_nxt = ERR_NONE;
                    w_busy_nxt     = 1'b1;
                    w_load_nxt     = 1'b1;
                    w_word_nxt     = build_word(1'b1, ADDR_CHIP_ID, 8'h00);
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (spi_busy) begin
                    w_state_nxt = WAIT_FALL;
                end else if (r_tmo == TMO_MAX) begin
                    w_state_nxt    = ERR;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_RISE_TMO;
                    w_busy_nxt     = 1'b0;
                end
            end
            WAIT_FALL: begin
                if (!spi_busy) begin
                    w_rd_byte_nxt = spi_rd_data;
                    w_state_nxt   = (r_idx == '0) ? CHECK : GAP;
                end else if (r_tmo == TMO_MAX) begin
                    w_state_nxt    = ERR;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_FALL_TMO;
                    w_busy_nxt     = 1'b0;
                end
            end
            CHECK: begin
                if (r_rd_byte == CHIP_ID_EXP) begin
                    w_state_nxt = GAP;
                end else begin
                    w_state_nxt    = ERR;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_CHIP_ID;
                    w_busy_nxt     = 1'b0;
                end
            end
            GAP: begin
                w_gap_nxt = r_gap + GAP_W'(1);
                if (r_gap == GAP_LAST) begin
                    if (r_idx == LAST_STEP) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_load_nxt  = 1'b1;
                        if (r_idx == XFER_PREV) begin
                            w_word_nxt = build_word(1'b0, ADDR_TRANSFER, DATA_TRANSFER);
                        end else begin
                            w_word_nxt = build_word(1'b0, w_entry.addr, w_entry.data);
                        end
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            ERR: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Both counters restart on every state entry
        if (w_state_nxt != r_state) begin
            w_tmo_nxt = '0;
            w_gap_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_word     <= '0;
            r_load     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_rd_byte  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_tmo      <= w_tmo_nxt;
            r_gap      <= w_gap_nxt;
            r_word     <= w_word_nxt;
            r_load     <= w_load_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_err_code <= w_err_code_nxt;
            r_rd_byte  <= w_rd_byte_nxt;
        end
    end

    assign spi_data[RW_POS]            = r_word.rw;
    assign spi_data[W_MSB:W_LSB]       = r_word.w;
    assign spi_data[ADDR_MSB:ADDR_LSB] = r_word.addr;
    assign spi_data[DATA_MSB:DATA_LSB] = r_word.data;
    assign spi_load                    = r_load;
    assign busy                        = r_busy;
    assign done                        = r_done;
    assign error                       = r_error;
    assign err_code                    = r_err_code;

endmodule

// File: tb/tb_ad9634_cfg_sequencer.sv
// Self-checking bench for ad9634_cfg_sequencer: SPI controller model with randomized
// busy timing and chip-ID responses, compared against an expected instruction list.
module tb_ad9634_cfg_sequencer;

    localparam int unsigned NUM_WRITES     = 8;
    localparam int unsigned GAP_CYCLES     = 16;
    localparam int unsigned TIMEOUT_CYCLES = 4096;
    localparam logic [7:0]  CHIP_ID        = 8'h87;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_SILENT = 1;
    localparam int MODE_STUCK  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        spi_busy;
    logic [7:0]  spi_rd_data;
    logic [23:0] spi_data;
    logic        spi_load;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    logic [12:0] tbl_addr [8] = '{13'h008, 13'h009, 13'h00B, 13'h00D,
                                  13'h010, 13'h014, 13'h016, 13'h018};
    logic [7:0]  tbl_data [8] = '{8'h00, 8'h01, 8'h00, 8'h00,
                                  8'h00, 8'h01, 8'h00, 8'h04};

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode    = MODE_NORMAL;
    int m_dly     = 2;
    int m_len     = 48;
    int m_stuck_n = 3;
    int m_base    = 0;

    int cyc      = 0;
    int done_cnt = 0;
    int pend     = 0;
    int t_rise   = 0;
    int t_fall   = 0;
    logic [23:0] load_w [$];
    int          load_t [$];
    int          fall_t [$];

    always #5 clk = ~clk;

    ad9634_cfg_sequencer #(
        .NUM_WRITES     (NUM_WRITES),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CHIP_ID_EXP    (CHIP_ID)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .spi_data    (spi_data),
        .spi_load    (spi_load),
        .spi_busy    (spi_busy),
        .spi_rd_data (spi_rd_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    // SPI controller model plus load/done monitor, all on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            spi_busy = 1'b0;
            pend     = 0;
        end else begin
            if (done) done_cnt++;
            if (spi_load) begin
                load_w.push_back(spi_data);
                load_t.push_back(cyc);
                if (m_mode != MODE_SILENT) begin
                    pend   = 1;
                    t_rise = cyc + m_dly;
                    if (m_mode == MODE_STUCK && (load_w.size() - m_base) >= m_stuck_n)
                        t_fall = -1;
                    else
                        t_fall = t_rise + m_len;
                end
            end
            if (pend != 0 && cyc == t_rise) spi_busy = 1'b1;
            if (pend != 0 && cyc == t_fall) begin
                spi_busy = 1'b0;
                pend     = 0;
                fall_t.push_back(cyc);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_word(input int stp);
        if (stp == 0)
            return {1'b1, 2'b00, 13'h001, 8'h00};
        else if (stp <= int'(NUM_WRITES))
            return {1'b0, 2'b00, tbl_addr[stp-1], tbl_data[stp-1]};
        else
            return {1'b0, 2'b00, 13'h0FF, 8'h01};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic pulse_start(output int s_cyc);
        step();
        start = 1'b1;
        s_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    // Full run in normal controller mode; expected result derived from the response byte
    task automatic run_and_check(input string tag, input int dly, input int len,
                                 input logic [7:0] resp, input bit poke);
        int lb, fb, db, s_cyc, k, n_exp, n_got;
        bit ok_id;
        m_mode      = MODE_NORMAL;
        m_dly       = dly;
        m_len       = len;
        spi_rd_data = resp;
        lb     = load_w.size();
        fb     = fall_t.size();
        db     = done_cnt;
        m_base = lb;
        pulse_start(s_cyc);
        k = 0;
        while (busy && k < 20000) begin
            step();
            k++;
            start = (poke && k == 150) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check_eq({tag, "_finish"}, 32'(k < 20000), 32'd1);
        ok_id = (resp == CHIP_ID);
        n_exp = ok_id ? int'(NUM_WRITES) + 2 : 1;
        n_got = load_w.size() - lb;
        check_eq({tag, "_nloads"}, 32'(n_got), 32'(n_exp));
        for (int i = 0; i < n_exp && i < n_got; i++) begin
            check_eq($sformatf("%s_word%0d", tag, i), 32'(load_w[lb+i]), 32'(exp_word(i)));
            if (i == 0)
                check_eq({tag, "_latency"}, 32'(load_t[lb] - s_cyc), 32'd1);
            else if (fb + i - 1 < fall_t.size())
                check_eq($sformatf("%s_gap%0d", tag, i),
                         32'(load_t[lb+i] - fall_t[fb+i-1]),
                         32'(int'(GAP_CYCLES) + 1 + ((i == 1) ? 1 : 0)));
        end
        check_eq({tag, "_done"}, 32'(done_cnt - db), 32'(ok_id ? 1 : 0));
        check_eq({tag, "_error"}, 32'(error), 32'(ok_id ? 0 : 1));
        check_eq({tag, "_code"}, 32'(err_code), 32'(ok_id ? 0 : 3));
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lb, db, s_cyc, k, dt;
        rst_n       = 1'b0;
        start       = 1'b0;
        spi_rd_data = 8'h00;
        step();
        check_eq("rst_load", 32'(spi_load), 32'd0);
        check_eq("rst_data", 32'(spi_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_flags", 32'({done, error, err_code}), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Nominal run with a start pulse injected mid-run, then a back-to-back rerun
        run_and_check("nominal", 2, 48, CHIP_ID, 1'b1);
        run_and_check("b2b", 2, 48, CHIP_ID, 1'b0);
        check_eq("b2b_same_span", 32'(load_t[load_t.size()-1] - load_t[load_t.size()-10]),
                 32'(load_t[load_t.size()-11] - load_t[load_t.size()-20]));

        run_and_check("mismatch", 2, 48, 8'h00, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] resp;
            resp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : CHIP_ID;
            repeat ($urandom_range(0, 5)) step();
            run_and_check($sformatf("rnd%0d", i), int'($urandom_range(1, 4)),
                          int'($urandom_range(1, 60)), resp, 1'b0);
        end

        // Controller never responds
        m_mode      = MODE_SILENT;
        spi_rd_data = CHIP_ID;
        lb = load_w.size();
        db = done_cnt;
        pulse_start(s_cyc);
        k = 0;
        while (busy && k < int'(TIMEOUT_CYCLES) + 200) begin
            step();
            k++;
        end
        dt = cyc - load_t[lb];
        check_eq("silent_window", 32'(dt >= int'(TIMEOUT_CYCLES) && dt <= int'(TIMEOUT_CYCLES) + 3), 32'd1);
        check_eq("silent_nloads", 32'(load_w.size() - lb), 32'd1);
        check_eq("silent_error", 32'(error), 32'd1);
        check_eq("silent_code", 32'(err_code), 32'd1);
        check_eq("silent_busy", 32'(busy), 32'd0);
        check_eq("silent_done", 32'(done_cnt - db), 32'd0);

        // Busy stuck high from the third load onwards
        m_mode    = MODE_STUCK;
        m_stuck_n = 3;
        m_dly     = 2;
        m_len     = 10;
        lb     = load_w.size();
        m_base = lb;
        db     = done_cnt;
        pulse_start(s_cyc);
        k = 0;
        while (busy && k < 20000) begin
            step();
            k++;
        end
        check_eq("stuck_finish", 32'(k < 20000), 32'd1);
        repeat (20) step();
        check_eq("stuck_nloads", 32'(load_w.size() - lb), 32'd3);
        for (int i = 0; i < 3 && lb + i < load_w.size(); i++)
            check_eq($sformatf("stuck_word%0d", i), 32'(load_w[lb+i]), 32'(exp_word(i)));
        check_eq("stuck_error", 32'(error), 32'd1);
        check_eq("stuck_code", 32'(err_code), 32'd2);
        check_eq("stuck_done", 32'(done_cnt - db), 32'd0);
        apply_reset();
        check_eq("post_rst_error", 32'(error), 32'd0);
        check_eq("post_rst_code", 32'(err_code), 32'd0);

        // Asynchronous reset while table entry 4 is in flight
        m_mode = MODE_NORMAL;
        m_dly  = 2;
        m_len  = 48;
        lb = load_w.size();
        pulse_start(s_cyc);
        k = 0;
        while ((load_w.size() - lb) < 6 && k < 5000) begin
            step();
            k++;
        end
        check_eq("arst_reach", 32'(k < 5000), 32'd1);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_eq("arst_load", 32'(spi_load), 32'd0);
        check_eq("arst_data", 32'(spi_data), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_flags", 32'({done, error, err_code}), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (100) step();
        check_eq("arst_no_loads", 32'(load_w.size() - lb), 32'd6);
        run_and_check("after_rst", 2, 48, CHIP_ID, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
